sample_packer: RTL and testbench
================================

// Module: sample_packer
// PURPOSE
//  Serial-to-parallel front end for parallel_accumulator.
//  - Accepts one DATA_WIDTH sample per valid/ready handshake.
//  - Packs PAR_FACTOR samples into a lane vector; lane 0 holds the first sample.
//  - Issues a one-cycle m_en pulse with the vector, driving the accumulator's data_in/en directly.
//  - s_last flushes a partial vector; the unused lanes are zero-filled.
// PARAMETERS
//  PAR_FACTOR  4  lanes per output vector (>=2)
//  DATA_WIDTH  4  bits per sample/lane
// PORTS
//  clk         in   1                      clock, rising edge
//  rst         in   1                      synchronous, active-low reset (0 = reset)
//  s_valid     in   1                      input sample valid
//  s_ready     out  1                      input can accept; = !hold (&& !stopped)
//  s_data      in   DATA_WIDTH             input sample
//  s_last      in   1                      sample closes the vector early (flush)
//  hold        in   1                      downstream stall request; blocks input only
//  m_data      out  [DATA_WIDTH-1:0] x PAR_FACTOR  packed vector (unpacked array)
//  m_en        out  1                      one-cycle strobe: m_data is new
//  m_lane_vld  out  PAR_FACTOR             mask of lanes filled from real samples
//  acc_ovf     in   1                      [PACKER_OVF_STOP_EN only] accumulator overflow flag
//  stopped     out  1                      [PACKER_OVF_STOP_EN only] sticky stop indicator
// BEHAVIOUR
//  - Reset (rst=0 at a clk edge):
//    - cnt=0, lane buffer=0, m_data=0, m_en=0, m_lane_vld=0, stopped=0.
//    - s_ready is low while reset is held.
//    - Any partial vector is discarded.
//  - Accept: s_valid && s_ready at a clk edge.
//    - buf[cnt] <= s_data; cnt increments; the cnt width is $clog2(PAR_FACTOR).
//  - Emit: on an accept with cnt==PAR_FACTOR-1 or s_last=1:
//    - next cycle m_data = buffer including this beat; lanes > cnt are zero.
//    - m_lane_vld = (1<<(cnt+1))-1 and m_en=1 for exactly one cycle.
//    - cnt returns to 0 and the buffer clears the same edge.
//  - Latency: 1 cycle from the final accepted beat to m_en. Throughput is 1 sample/cycle with no bubble between vectors.
//  - m_data/m_lane_vld hold their last value between pulses. There is no output backpressure; the consumer always takes m_en.
//  - States: IDLE (cnt==0), FILL (0<cnt), STOP (macro only).
//    - IDLE -> FILL on an accept without emit.
//    - FILL -> IDLE on emit.
//    - any -> IDLE on reset.
//  - s_last on lane PAR_FACTOR-1 gives a single full vector (mask all ones), not an extra empty one.
//  - s_last with cnt==0 emits a 1-lane vector.
//  - hold=1: s_ready=0 combinationally and no accept occurs.
//    - A pending m_en pulse still fires.
//    - The partial buffer is retained unchanged.
//  - s_valid without s_ready: s_data is ignored; the source must hold it stable.
// CONFIGURATION
//  - PACKER_OVF_STOP_EN defined: acc_ovf=1 at an edge sets sticky stopped=1 from the next cycle.
//    - While stopped=1: s_ready=0, no further m_en, and the partial buffer is frozen.
//    - Only reset clears stopped.
//    - A beat accepted in the same cycle that acc_ovf rises is still processed, including its emit.
//  - Undefined: the acc_ovf/stopped ports are absent and behaviour is as above with stopped==0.
// STRUCTURE
//  - Package packer_pkg:
//    - typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_STOP} packer_state_e;
//    - function cnt_w(par) returning $clog2(par).
//  - No sub-module. Counter, lane buffer and output register are coded inline; the lane write is a decoded enable per lane.
// TESTING (PAR_FACTOR=4, DATA_WIDTH=4)
//  1. rst=0 for 2 edges -> m_en=0, m_data={0,0,0,0}, m_lane_vld=0, s_ready=0. After rst=1 -> s_ready=1.
//  2. Beats 1,2,3,4 back-to-back -> one cycle after beat 4: m_en=1 for one cycle, m_data={1,2,3,4} (lane0=1), m_lane_vld=4'b1111.
//  3. Beats 5,6 with s_last on 6 -> m_data={5,6,0,0}, m_lane_vld=4'b0011, single m_en. Next beats 7,8,9,10 -> {7,8,9,10} with no gap.
//  4. After 2 beats, hold=1 for 3 cycles with s_valid=1, s_data=7 -> s_ready=0, cnt stays 2. Release -> 7 lands in lane 2; vector completes normally.
//  5. rst=0 after 3 beats of a vector -> no m_en, outputs zero. Next 4 beats 1..4 -> clean {1,2,3,4}.
//  6. (PACKER_OVF_STOP_EN) acc_ovf pulse on beat 4's cycle -> vector still emitted, stopped=1, s_ready=0 until rst.

Source files
------------

// File: rtl/packer_pkg.sv
// Shared types and helpers for sample_packer.
package packer_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_STOP} packer_state_e;

    function automatic int cnt_w(input int par);
        return $clog2(par);
    endfunction

endpackage

// File: rtl/sample_packer.sv
// Serial-to-parallel packer: PAR_FACTOR samples per vector, s_last flushes early.
// Optional PACKER_OVF_STOP_EN adds acc_ovf/stopped sticky stop on accumulator overflow.
module sample_packer
    import packer_pkg::*;
#(
    parameter int PAR_FACTOR = 4,
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  hold,
    output logic [DATA_WIDTH-1:0] m_data [PAR_FACTOR],
    output logic                  m_en,
    output logic [PAR_FACTOR-1:0] m_lane_vld
`ifdef PACKER_OVF_STOP_EN
    ,
    input  logic                  acc_ovf,
    output logic                  stopped
`endif
);

    localparam int               CNT_W    = cnt_w(PAR_FACTOR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAR_FACTOR - 1);

    packer_state_e state, state_next;

    logic [CNT_W-1:0]      cnt;
    logic [DATA_WIDTH-1:0] lane_buf [PAR_FACTOR];
    logic [DATA_WIDTH-1:0] emit_vec [PAR_FACTOR];
    logic [PAR_FACTOR-1:0] lane_we;
    logic [PAR_FACTOR-1:0] vld_next;
    logic                  halted;
    logic                  accept;
    logic                  emit;

`ifdef PACKER_OVF_STOP_EN
    assign halted  = (state == ST_STOP);
    assign stopped = halted;
`else
    assign halted  = 1'b0;
`endif

    assign s_ready = rst && !hold && !halted;
    assign accept  = s_valid && s_ready;
    assign emit    = accept && ((cnt == CNT_LAST) || s_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: if (accept && !emit) state_next = ST_FILL;
            ST_FILL: if (emit)            state_next = ST_IDLE;
            default:                      state_next = state;
        endcase
`ifdef PACKER_OVF_STOP_EN
        // The beat accepted alongside acc_ovf is still buffered/emitted this edge.
        if (acc_ovf) state_next = ST_STOP;
`endif
    end

    always_comb begin
        lane_we  = '0;
        vld_next = '0;
        for (int unsigned i = 0; i < PAR_FACTOR; i++) begin
            lane_we[i]  = accept && (32'(cnt) == i);
            vld_next[i] = (i <= 32'(cnt));
            if (i < 32'(cnt)) begin
                emit_vec[i] = lane_buf[i];
            end else if (lane_we[i]) begin
                emit_vec[i] = s_data;
            end else begin
                emit_vec[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (emit) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < PAR_FACTOR; i++) begin
            if (!rst || emit) begin
                lane_buf[i] <= '0;
            end else if (lane_we[i]) begin
                lane_buf[i] <= s_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m_en       <= 1'b0;
            m_lane_vld <= '0;
            for (int unsigned i = 0; i < PAR_FACTOR; i++) begin
                m_data[i] <= '0;
            end
        end else begin
            m_en <= emit;
            if (emit) begin
                m_lane_vld <= vld_next;
                for (int unsigned i = 0; i < PAR_FACTOR; i++) begin
                    m_data[i] <= emit_vec[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_packer.sv
// Table-driven bench for sample_packer (PAR_FACTOR=4, DATA_WIDTH=4); define PACKER_OVF_STOP_EN to cover the stop feature.
module tb_sample_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [3:0] s_data = '0;
    logic       s_last = 1'b0;
    logic       hold = 1'b0;
    logic [3:0] m_data [4];
    logic       m_en;
    logic [3:0] m_lane_vld;
    logic       acc_ovf = 1'b0;
`ifdef PACKER_OVF_STOP_EN
    logic       stopped;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    sample_packer #(
        .PAR_FACTOR(4),
        .DATA_WIDTH(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_last     (s_last),
        .hold       (hold),
        .m_data     (m_data),
        .m_en       (m_en),
        .m_lane_vld (m_lane_vld)
`ifdef PACKER_OVF_STOP_EN
        ,
        .acc_ovf    (acc_ovf),
        .stopped    (stopped)
`endif
    );

    // exp_data packs lanes as {lane3, lane2, lane1, lane0}
    typedef struct {
        logic        rst;
        logic        valid;
        logic [3:0]  data;
        logic        last;
        logic        hold;
        logic        exp_ready;
        logic        exp_en;
        logic [15:0] exp_data;
        logic [3:0]  exp_vld;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic v, input logic [3:0] d, input logic l,
                       input logic h, input logic er, input logic ee,
                       input logic [15:0] ed, input logic [3:0] ev);
        vec_t t;
        t.rst = r; t.valid = v; t.data = d; t.last = l; t.hold = h;
        t.exp_ready = er; t.exp_en = ee; t.exp_data = ed; t.exp_vld = ev;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] packed_out();
        return {m_data[3], m_data[2], m_data[1], m_data[0]};
    endfunction

    task automatic step(input string tag, input vec_t t);
        @(negedge clk);
        rst = t.rst; s_valid = t.valid; s_data = t.data; s_last = t.last; hold = t.hold;
        #1;
        chk({tag, " s_ready"}, 32'(s_ready), 32'(t.exp_ready));
        @(posedge clk);
        #1;
        chk({tag, " m_en"}, 32'(m_en), 32'(t.exp_en));
        chk({tag, " m_data"}, 32'(packed_out()), 32'(t.exp_data));
        chk({tag, " m_lane_vld"}, 32'(m_lane_vld), 32'(t.exp_vld));
    endtask

    task automatic beat(input string tag, input logic [3:0] d, input logic l, input logic ee,
                        input logic [15:0] ed, input logic [3:0] ev);
        vec_t t;
        t.rst = 1'b1; t.valid = 1'b1; t.data = d; t.last = l; t.hold = 1'b0;
        t.exp_ready = 1'b1; t.exp_en = ee; t.exp_data = ed; t.exp_vld = ev;
        step(tag, t);
    endtask

    initial begin
        // reset held two edges; valid during reset is ignored
        add(0, 0, 4'h0, 0, 0,  0, 0, 16'h0000, 4'h0);
        add(0, 1, 4'h5, 0, 0,  0, 0, 16'h0000, 4'h0);
        // full vector 1..4
        add(1, 1, 4'h1, 0, 0,  1, 0, 16'h0000, 4'h0);
        add(1, 1, 4'h2, 0, 0,  1, 0, 16'h0000, 4'h0);
        add(1, 1, 4'h3, 0, 0,  1, 0, 16'h0000, 4'h0);
        add(1, 1, 4'h4, 0, 0,  1, 1, 16'h4321, 4'hF);
        // flush after 2 lanes, then full vector with no gap
        add(1, 1, 4'h5, 0, 0,  1, 0, 16'h4321, 4'hF);
        add(1, 1, 4'h6, 1, 0,  1, 1, 16'h0065, 4'h3);
        add(1, 1, 4'h7, 0, 0,  1, 0, 16'h0065, 4'h3);
        add(1, 1, 4'h8, 0, 0,  1, 0, 16'h0065, 4'h3);
        add(1, 1, 4'h9, 0, 0,  1, 0, 16'h0065, 4'h3);
        add(1, 1, 4'hA, 0, 0,  1, 1, 16'hA987, 4'hF);
        // hold mid-vector keeps cnt at 2
        add(1, 1, 4'h1, 0, 0,  1, 0, 16'hA987, 4'hF);
        add(1, 1, 4'h2, 0, 0,  1, 0, 16'hA987, 4'hF);
        add(1, 1, 4'h7, 0, 1,  0, 0, 16'hA987, 4'hF);
        add(1, 1, 4'h7, 0, 1,  0, 0, 16'hA987, 4'hF);
        add(1, 1, 4'h7, 0, 1,  0, 0, 16'hA987, 4'hF);
        add(1, 1, 4'h7, 0, 0,  1, 0, 16'hA987, 4'hF);
        add(1, 1, 4'h8, 0, 0,  1, 1, 16'h8721, 4'hF);
        // reset after 3 beats discards the partial vector
        add(1, 1, 4'h1, 0, 0,  1, 0, 16'h8721, 4'hF);
        add(1, 1, 4'h2, 0, 0,  1, 0, 16'h8721, 4'hF);
        add(1, 1, 4'h3, 0, 0,  1, 0, 16'h8721, 4'hF);
        add(0, 1, 4'h4, 0, 0,  0, 0, 16'h0000, 4'h0);
        add(1, 1, 4'h1, 0, 0,  1, 0, 16'h0000, 4'h0);
        add(1, 1, 4'h2, 0, 0,  1, 0, 16'h0000, 4'h0);
        add(1, 1, 4'h3, 0, 0,  1, 0, 16'h0000, 4'h0);
        add(1, 1, 4'h4, 0, 0,  1, 1, 16'h4321, 4'hF);
        // s_last at cnt 0 -> single lane
        add(1, 1, 4'h9, 1, 0,  1, 1, 16'h0009, 4'h1);
        // s_last on the final lane -> one full vector, no empty follow-up
        add(1, 1, 4'h1, 0, 0,  1, 0, 16'h0009, 4'h1);
        add(1, 1, 4'h2, 0, 0,  1, 0, 16'h0009, 4'h1);
        add(1, 1, 4'h3, 0, 0,  1, 0, 16'h0009, 4'h1);
        add(1, 1, 4'h4, 1, 0,  1, 1, 16'h4321, 4'hF);
        add(1, 0, 4'h0, 0, 0,  1, 0, 16'h4321, 4'hF);
        add(1, 0, 4'h5, 1, 0,  1, 0, 16'h4321, 4'hF);
        add(1, 1, 4'h6, 1, 0,  1, 1, 16'h0006, 4'h1);

        foreach (vecs[i]) step($sformatf("row%0d", i), vecs[i]);

        // hold raised in the cycle the pulse is out: pulse still visible, nothing accepted
        beat("pend b1", 4'h1, 0, 0, 16'h0006, 4'h1);
        beat("pend b2", 4'h2, 0, 0, 16'h0006, 4'h1);
        beat("pend b3", 4'h3, 0, 0, 16'h0006, 4'h1);
        beat("pend b4", 4'h4, 0, 1, 16'h4321, 4'hF);
        @(negedge clk);
        hold = 1'b1; s_data = 4'h9; s_last = 1'b0;
        #1;
        chk("pend hold s_ready", 32'(s_ready), 32'(0));
        chk("pend hold m_en", 32'(m_en), 32'(1));
        repeat (2) @(posedge clk);
        #1;
        chk("pend after m_en", 32'(m_en), 32'(0));
        chk("pend after m_data", 32'(packed_out()), 32'(16'h4321));
        beat("pend release", 4'h5, 1, 1, 16'h0005, 4'h1);

`ifdef PACKER_OVF_STOP_EN
        beat("ovf b1", 4'h1, 0, 0, 16'h0005, 4'h1);
        beat("ovf b2", 4'h2, 0, 0, 16'h0005, 4'h1);
        beat("ovf b3", 4'h3, 0, 0, 16'h0005, 4'h1);
        @(negedge clk);
        s_data = 4'h4; acc_ovf = 1'b1;
        #1;
        chk("ovf stopped before", 32'(stopped), 32'(0));
        @(posedge clk);
        #1;
        chk("ovf m_en", 32'(m_en), 32'(1));
        chk("ovf m_data", 32'(packed_out()), 32'(16'h4321));
        chk("ovf stopped", 32'(stopped), 32'(1));
        @(negedge clk);
        acc_ovf = 1'b0; s_data = 4'h5;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk($sformatf("stop%0d s_ready", k), 32'(s_ready), 32'(0));
            @(posedge clk);
            #1;
            chk($sformatf("stop%0d m_en", k), 32'(m_en), 32'(0));
            chk($sformatf("stop%0d stopped", k), 32'(stopped), 32'(1));
            @(negedge clk);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("stop rst stopped", 32'(stopped), 32'(0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("stop rst s_ready", 32'(s_ready), 32'(1));
`endif

        @(negedge clk);
        s_valid = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
